// File: rtl/risc_v_mc_pkg.sv
// Shared opcodes, FSM states and ALU codes for the multi-cycle core.
package risc_v_mc_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        TRAP
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

endpackage

// File: rtl/risc_v_mc_regfile.sv
// Register file: two async reads, one sync write, x0 hardwired to zero.
module risc_v_mc_regfile
    import risc_v_mc_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            for (int i = 1; i < NUM_REGS; i++)
                if (waddr == 5'(i))
                    regs[i] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == 5'(i))
                rdata1 = regs[i];
            if (raddr2 == 5'(i))
                rdata2 = regs[i];
        end
    end

endmodule

// File: rtl/risc_v_multi_cycle.sv
// Multi-cycle RV32I/RV32E-subset core sharing one req/ready memory port.
module risc_v_multi_cycle
    import risc_v_mc_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ready_i,
    output logic            retire_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [XLEN-1:0] pc_o,
    output logic            trap_o
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("risc_v_multi_cycle: XLEN must be 32");
    end
    if (NUM_REGS != 16 && NUM_REGS != 32) begin : g_bad_regs
        $error("risc_v_multi_cycle: NUM_REGS must be 16 or 32");
    end

    state_e          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx, ir, a, b, imm, alu_out, mdr;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_nx;
    logic [XLEN-1:0] op_a, op_b, alu_res, wb_val, addr;
    logic [6:0]      opcode, f7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            is_op, is_op_imm, is_lui, is_load, is_store;
    logic            is_branch, is_jal, is_jalr;
    logic            legal, use_rs1, use_rs2, use_rd, bad_reg;
    logic            req, we, rf_we, retire, taken;
    alu_op_e         alu_op;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    assign is_op     = opcode == OP;
    assign is_op_imm = opcode == OP_IMM;
    assign is_lui    = opcode == LUI;
    assign is_load   = opcode == LOAD;
    assign is_store  = opcode == STORE;
    assign is_branch = opcode == BRANCH;
    assign is_jal    = opcode == JAL;
    assign is_jalr   = opcode == JALR;

    function automatic logic out_of_range(logic [4:0] r);
        return int'(r) >= NUM_REGS;
    endfunction

    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        use_rd  = 1'b1;
        imm_nx  = {{20{ir[31]}}, ir[31:20]};
        unique case (opcode)
            OP: begin
                legal = (f7 == 7'b0 && f3 inside {3'b000, 3'b111, 3'b110, 3'b010})
                     || (f7 == 7'b0100000 && f3 == 3'b000);
                use_rs2 = 1'b1;
            end
            OP_IMM: legal = f3 inside {3'b000, 3'b111, 3'b110, 3'b010};
            LUI: begin
                legal   = 1'b1;
                use_rs1 = 1'b0;
                imm_nx  = {ir[31:12], 12'b0};
            end
            LOAD: legal = f3 == 3'b010;
            STORE: begin
                legal   = f3 == 3'b010;
                use_rs2 = 1'b1;
                use_rd  = 1'b0;
                imm_nx  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            BRANCH: begin
                legal   = f3 == 3'b000 || f3 == 3'b001;
                use_rs2 = 1'b1;
                use_rd  = 1'b0;
                imm_nx  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            JAL: begin
                legal   = 1'b1;
                use_rs1 = 1'b0;
                imm_nx  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            JALR: legal = f3 == 3'b000;
            default: legal = 1'b0;
        endcase
    end

    assign bad_reg = (use_rs1 && out_of_range(rs1))
                  || (use_rs2 && out_of_range(rs2))
                  || (use_rd && out_of_range(rd));

    always_comb begin
        alu_op = ALU_ADD;
        if (is_op || is_op_imm) begin
            unique case (1'b1)
                f3 == 3'b111:                       alu_op = ALU_AND;
                f3 == 3'b110:                       alu_op = ALU_OR;
                f3 == 3'b010:                       alu_op = ALU_SLT;
                is_op && f7[5] && f3 == 3'b000:     alu_op = ALU_SUB;
                default:                            alu_op = ALU_ADD;
            endcase
        end
    end

    // Jumps reuse the adder to form the link value pc + 4.
    assign op_a = (is_jal || is_jalr) ? pc : (is_lui ? '0 : a);
    assign op_b = is_op ? b : ((is_jal || is_jalr) ? 32'd4 : imm);

    always_comb begin
        unique case (alu_op)
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default: alu_res = op_a + op_b;
        endcase
    end

    assign taken = (a == b) ^ f3[0];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        req      = 1'b0;
        we       = 1'b0;
        addr     = '0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        wb_val   = '0;
        unique case (state)
            FETCH: begin
                if (pc[1:0] != 2'b00) begin
                    state_nx = TRAP;
                end else begin
                    req  = 1'b1;
                    addr = {pc[XLEN-1:2], 2'b00};
                    if (mem_ready_i)
                        state_nx = DECODE;
                end
            end
            DECODE: state_nx = (!legal || bad_reg) ? TRAP : EXECUTE;
            EXECUTE: begin
                if (is_load || is_store) begin
                    state_nx = (alu_res[1:0] != 2'b00) ? TRAP : MEM;
                end else if (is_branch) begin
                    pc_nx    = taken ? pc + imm : pc + 32'd4;
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = WRITEBACK;
                end
            end
            MEM: begin
                req  = 1'b1;
                we   = is_store;
                addr = {alu_out[XLEN-1:2], 2'b00};
                if (mem_ready_i) begin
                    if (is_store) begin
                        retire   = 1'b1;
                        pc_nx    = pc + 32'd4;
                        state_nx = FETCH;
                    end else begin
                        state_nx = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                rf_we    = 1'b1;
                retire   = 1'b1;
                wb_val   = is_load ? mdr : alu_out;
                state_nx = FETCH;
                if (is_jal)
                    pc_nx = pc + imm;
                else if (is_jalr)
                    pc_nx = (a + imm) & ~32'h1;
                else
                    pc_nx = pc + 32'd4;
            end
            TRAP: state_nx = TRAP;
            default: state_nx = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == FETCH && mem_ready_i)
                ir <= mem_rdata_i;
            if (state == DECODE) begin
                a   <= rs1_val;
                b   <= rs2_val;
                imm <= imm_nx;
            end
            if (state == EXECUTE)
                alu_out <= alu_res;
            if (state == MEM && mem_ready_i && is_load)
                mdr <= mem_rdata_i;
        end
    end

    risc_v_mc_regfile #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (reset),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (wb_val)
    );

    // Gating with reset drops the request the instant reset asserts.
    assign mem_req_o   = req & reset;
    assign mem_we_o    = we & reset;
    assign mem_addr_o  = addr;
    assign mem_wdata_o = (state == MEM && is_store) ? b : '0;
    assign retire_o    = retire;
    assign wb_data_o   = wb_val;
    assign pc_o        = pc;
    assign trap_o      = state == TRAP;

endmodule

// File: tb/tb_risc_v_multi_cycle.sv
// Directed bench for risc_v_multi_cycle with a zero/variable-wait memory model.
module tb_risc_v_multi_cycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        retire_o, trap_o;
    logic [31:0] wb_data_o, pc_o;

    logic        reset2 = 1'b1;
    logic        req2, we2, retire2, trap2;
    logic [31:0] addr2, wdata2, wb2, pc2;

    logic [31:0] prog [64];
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0;
    int          wr_cnt = 0, xfer_cnt = 0;
    int          errors = 0, checks = 0, n = 0;

    always #5 clk = ~clk;

    risc_v_multi_cycle dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .retire_o    (retire_o),
        .wb_data_o   (wb_data_o),
        .pc_o        (pc_o),
        .trap_o      (trap_o)
    );

    risc_v_multi_cycle #(.NUM_REGS(16)) dut_e (
        .clk         (clk),
        .reset       (reset2),
        .mem_req_o   (req2),
        .mem_we_o    (we2),
        .mem_addr_o  (addr2),
        .mem_wdata_o (wdata2),
        .mem_rdata_i (32'h00100A13),
        .mem_ready_i (1'b1),
        .retire_o    (retire2),
        .wb_data_o   (wb2),
        .pc_o        (pc2),
        .trap_o      (trap2)
    );

    // One store slot overlays the program image; reset empties it.
    assign mem_rdata_i = (st_valid && mem_addr_o == st_addr) ? st_data :
                         (mem_addr_o < 32'd256) ? prog[mem_addr_o[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (!reset) begin
            st_valid <= 1'b0;
        end else if (mem_req_o && mem_ready_i) begin
            xfer_cnt <= xfer_cnt + 1;
            if (mem_we_o) begin
                st_valid <= 1'b1;
                st_addr  <= mem_addr_o;
                st_data  <= mem_wdata_o;
                wr_cnt   <= wr_cnt + 1;
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 64; i++)
            prog[i] = 32'h0000_0013;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        n++;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        mem_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n = 1;
    endtask

    task automatic wait_retire(output int at, output logic [31:0] wb, output logic [31:0] pcv);
        at = -1;
        wb = '0;
        pcv = '0;
        for (int i = 0; i < 20; i++) begin
            if (retire_o) begin
                at = n;
                wb = wb_data_o;
                pcv = pc_o;
                break;
            end
            step();
        end
    endtask

    task automatic wait_trap();
        for (int i = 0; i < 10; i++) begin
            if (trap_o)
                break;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", mem_req_o); end
        checks++; if (retire_o !== 1'b0) begin errors++; $display("FAIL reset_retire got=%0h exp=0", retire_o); end
        checks++; if (trap_o !== 1'b0) begin errors++; $display("FAIL reset_trap got=%0h exp=0", trap_o); end
        checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL reset_wb got=%0h exp=0", wb_data_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", pc_o); end
    endtask

    task automatic test_alu();
        int at;
        logic [31:0] wb, pcv;
        clear_prog();
        prog[0]  = 32'h00500093;
        prog[1]  = 32'h00108133;
        prog[2]  = 32'h00202423;
        prog[3]  = 32'h00802183;
        prog[4]  = 32'h00000463;
        prog[6]  = 32'h010000EF;
        prog[10] = 32'hFFC08313;
        prog[11] = 32'hFFD00413;
        prog[12] = 32'h001424B3;
        prog[13] = 32'hFFFFFFFF;
        release_reset();
        checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0}) begin errors++; $display("FAIL first_fetch got=%0h/%0h/%0h exp=1/0/0", mem_req_o, mem_we_o, mem_addr_o); end
        wait_retire(at, wb, pcv);
        checks++; if (at !== 4) begin errors++; $display("FAIL addi_cycle got=%0d exp=4", at); end
        checks++; if (wb !== 32'd5) begin errors++; $display("FAIL addi_wb got=%0h exp=5", wb); end
        checks++; if (pcv !== 32'h0) begin errors++; $display("FAIL addi_pc got=%0h exp=0", pcv); end
        step();
        wait_retire(at, wb, pcv);
        checks++; if (at !== 8) begin errors++; $display("FAIL add_cycle got=%0d exp=8", at); end
        checks++; if (wb !== 32'd10) begin errors++; $display("FAIL add_wb got=%0h exp=a", wb); end
        checks++; if (pcv !== 32'h4) begin errors++; $display("FAIL add_pc got=%0h exp=4", pcv); end
        step();
    endtask

    task automatic test_store_load();
        int at, w0;
        logic [31:0] wb, pcv;
        w0 = wr_cnt;
        wait_retire(at, wb, pcv);
        checks++; if (at !== 12) begin errors++; $display("FAIL sw_cycle got=%0d exp=12", at); end
        checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h8, 32'd10}) begin errors++; $display("FAIL sw_bus got=%0h/%0h/%0h exp=1/8/a", mem_we_o, mem_addr_o, mem_wdata_o); end
        step();
        checks++; if (wr_cnt !== w0 + 1) begin errors++; $display("FAIL sw_count got=%0d exp=%0d", wr_cnt, w0 + 1); end
        wait_retire(at, wb, pcv);
        checks++; if (at !== 17) begin errors++; $display("FAIL lw_cycle got=%0d exp=17", at); end
        checks++; if (wb !== 32'd10) begin errors++; $display("FAIL lw_wb got=%0h exp=a", wb); end
        checks++; if (pcv !== 32'hC) begin errors++; $display("FAIL lw_pc got=%0h exp=c", pcv); end
        step();
    endtask

    task automatic test_branch_jump();
        int at, w0;
        logic [31:0] wb, pcv;
        w0 = wr_cnt;
        wait_retire(at, wb, pcv);
        checks++; if ({at, wb, pcv} !== {32'd20, 32'h0, 32'h10}) begin errors++; $display("FAIL beq_retire got=%0d/%0h/%0h exp=20/0/10", at, wb, pcv); end
        step();
        checks++; if (mem_addr_o !== 32'h18) begin errors++; $display("FAIL beq_target got=%0h exp=18", mem_addr_o); end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL beq_nowrite got=%0d exp=%0d", wr_cnt, w0); end
        wait_retire(at, wb, pcv);
        checks++; if ({at, wb, pcv} !== {32'd24, 32'h1C, 32'h18}) begin errors++; $display("FAIL jal_retire got=%0d/%0h/%0h exp=24/1c/18", at, wb, pcv); end
        step();
        checks++; if (mem_addr_o !== 32'h28) begin errors++; $display("FAIL jal_target got=%0h exp=28", mem_addr_o); end
        wait_retire(at, wb, pcv);
        checks++; if ({at, wb} !== {32'd28, 32'h18}) begin errors++; $display("FAIL link_reg got=%0d/%0h exp=28/18", at, wb); end
        step();
        wait_retire(at, wb, pcv);
        checks++; if (wb !== 32'hFFFF_FFFD) begin errors++; $display("FAIL addi_neg got=%0h exp=fffffffd", wb); end
        step();
        wait_retire(at, wb, pcv);
        checks++; if ({at, wb} !== {32'd36, 32'h1}) begin errors++; $display("FAIL slt_signed got=%0d/%0h exp=36/1", at, wb); end
        step();
    endtask

    task automatic test_illegal_trap();
        int x0;
        wait_trap();
        checks++; if ({trap_o, n} !== {1'b1, 32'd39}) begin errors++; $display("FAIL illegal_trap got=%0h@%0d exp=1@39", trap_o, n); end
        x0 = xfer_cnt;
        repeat (5) step();
        checks++; if (xfer_cnt !== x0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL trap_quiet got=%0d/%0h exp=%0d/0", xfer_cnt, mem_req_o, x0); end
        checks++; if ({trap_o, pc_o} !== {1'b1, 32'h34}) begin errors++; $display("FAIL trap_hold got=%0h/%0h exp=1/34", trap_o, pc_o); end
        reset = 1'b0;
        #1;
        checks++; if (trap_o !== 1'b0) begin errors++; $display("FAIL trap_clear got=%0h exp=0", trap_o); end
        clear_prog();
        prog[0] = 32'h00202183;
        release_reset();
        checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL restart_fetch got=%0h/%0h exp=1/0", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_misaligned();
        int x0;
        wait_trap();
        checks++; if ({trap_o, n} !== {1'b1, 32'd4}) begin errors++; $display("FAIL lw_misalign got=%0h@%0d exp=1@4", trap_o, n); end
        x0 = xfer_cnt;
        repeat (4) step();
        checks++; if (xfer_cnt !== x0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL misalign_quiet got=%0d/%0h exp=%0d/0", xfer_cnt, mem_req_o, x0); end
    endtask

    task automatic test_stall();
        int at, w0;
        logic [31:0] wb, pcv;
        clear_prog();
        prog[0] = 32'h00500093;
        prog[1] = 32'h00102623;
        release_reset();
        mem_ready_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL fetch_stall%0d got=%0h/%0h exp=1/0", i, mem_req_o, mem_addr_o); end
            step();
        end
        mem_ready_i = 1'b1;
        #1;
        wait_retire(at, wb, pcv);
        checks++; if ({at, wb} !== {32'd7, 32'd5}) begin errors++; $display("FAIL fetch_slip got=%0d/%0h exp=7/5", at, wb); end
        while (n < 11) step();
        mem_ready_i = 1'b0;
        #1;
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'hC, 32'd5}) begin errors++; $display("FAIL store_stall%0d got=%0h/%0h/%0h/%0h exp=1/1/c/5", i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
            step();
        end
        mem_ready_i = 1'b1;
        #1;
        wait_retire(at, wb, pcv);
        checks++; if ({at, pcv} !== {32'd14, 32'h4}) begin errors++; $display("FAIL store_slip got=%0d/%0h exp=14/4", at, pcv); end
        step();
        checks++; if (wr_cnt !== w0 + 1 || st_addr !== 32'hC || st_data !== 32'd5) begin errors++; $display("FAIL store_commit got=%0d/%0h/%0h exp=%0d/c/5", wr_cnt, st_addr, st_data, w0 + 1); end
    endtask

    task automatic test_async_reset();
        int at;
        logic [31:0] wb, pcv;
        clear_prog();
        prog[0] = 32'h00500093;
        release_reset();
        mem_ready_i = 1'b0;
        step();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({mem_req_o, pc_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL async_drop got=%0h/%0h exp=0/0", mem_req_o, pc_o); end
        release_reset();
        wait_retire(at, wb, pcv);
        checks++; if ({at, wb, pcv} !== {32'd4, 32'd5, 32'h0}) begin errors++; $display("FAIL async_restart got=%0d/%0h/%0h exp=4/5/0", at, wb, pcv); end
    endtask

    task automatic test_rv32e();
        int m;
        reset2 = 1'b0;
        repeat (2) @(negedge clk);
        reset2 = 1'b1;
        #1;
        m = 1;
        checks++; if (req2 !== 1'b1) begin errors++; $display("FAIL e_fetch got=%0h exp=1", req2); end
        for (int i = 0; i < 10; i++) begin
            if (trap2)
                break;
            @(negedge clk);
            #1;
            m++;
        end
        checks++; if ({trap2, m} !== {1'b1, 32'd3}) begin errors++; $display("FAIL e_reg_trap got=%0h@%0d exp=1@3", trap2, m); end
        checks++; if ({req2, retire2} !== 2'b00) begin errors++; $display("FAIL e_quiet got=%0h/%0h exp=0/0", req2, retire2); end
    endtask

    initial begin
        mem_ready_i = 1'b1;
        clear_prog();
        test_reset();
        test_alu();
        test_store_load();
        test_branch_jump();
        test_illegal_trap();
        test_misaligned();
        test_stall();
        test_async_reset();
        test_rv32e();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
